avm_burst_responder: RTL and testbench



---
 rtl/avm_burst_responder_pkg.sv | 20 ++
 rtl/dp_ram.sv | 43 ++++
 rtl/avm_burst_responder.sv | 138 +++++++++++++
 tb/tb_avm_burst_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_burst_responder_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
// Holds the FSM state encoding, the command field widths and the burstcount helper.
package avm_burst_responder_pkg;

  localparam int BCNT_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD       = 2'd1,
    ST_RD_DRAIN = 2'd2,
    ST_WR       = 2'd3
  } state_e;

  // A burstcount of zero is serviced as a single beat.
  function automatic logic [BCNT_W-1:0] eff_count(input logic [BCNT_W-1:0] bc);
    return (bc == '0) ? BCNT_W'(1) : bc;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: port A writes with byte enables, port B reads with one-cycle latency.
// OP_REGISTERED = "REGISTERED" adds a second output register stage on port B.
module dp_ram #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_WIDTH    = 10,
  parameter string OP_REGISTERED = "UNREGISTERED",
  parameter string INIT_FILE     = "UNUSED"
) (
  input  logic                    clk,
  input  logic                    wren_a,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic [DATA_WIDTH/8-1:0] byteena_a,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  output logic [DATA_WIDTH-1:0]   q_b
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wren_a) begin
      for (int b = 0; b < NB; b++) begin
        if (byteena_a[b]) mem[address_a][8*b +: 8] <= data_a[8*b +: 8];
      end
    end
    rd_q <= mem[address_b];
  end

  generate
    if (OP_REGISTERED == "REGISTERED") begin : g_opreg
      logic [DATA_WIDTH-1:0] rd2_q;
      always_ff @(posedge clk) rd2_q <= rd_q;
      assign q_b = rd2_q;
    end else begin : g_noopreg
      assign q_b = rd_q;
    end
  endgenerate

endmodule

// File: rtl/avm_burst_responder.sv
// Avalon-MM burst slave backed by a dual-port RAM: read bursts stream one word per
// cycle after a one-cycle RAM latency, write bursts accept beats with optional gaps.
module avm_burst_responder
  import avm_burst_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = "UNUSED"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       avs_address,
  input  logic [BCNT_W-1:0] avs_burstcount,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              busy,
  output logic              burst_done
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [BCNT_W-1:0]       cnt_q, cnt_d;
  logic                    rvld_q;
  logic                    done_q, done_d;
  logic                    busy_q;
  logic                    wait_q;

  logic [ADDR_WIDTH-1:0]   start_addr;
  logic [BCNT_W-1:0]       n_eff;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    unused_addr_bits;

  assign start_addr       = avs_address[ADDR_WIDTH+1:2];
  assign n_eff            = eff_count(avs_burstcount);
  assign unused_addr_bits = ^{avs_address[31:ADDR_WIDTH+2], avs_address[1:0]};

  // ptr_q is the next word to touch in either burst direction; cnt_q counts what is left.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (avs_write) begin
          ram_we    = 1'b1;
          ram_waddr = start_addr;
          if (n_eff == BCNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_WR;
            ptr_d   = start_addr + ADDR_WIDTH'(1);
            cnt_d   = n_eff - BCNT_W'(1);
          end
        end else if (avs_read) begin
          state_d = ST_RD;
          ptr_d   = start_addr;
          cnt_d   = n_eff;
        end
      end
      ST_RD: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        cnt_d = cnt_q - BCNT_W'(1);
        if (cnt_q == BCNT_W'(1)) begin
          state_d = ST_RD_DRAIN;
          done_d  = 1'b1;
        end
      end
      ST_RD_DRAIN: begin
        state_d = ST_IDLE;
      end
      ST_WR: begin
        if (avs_write) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - BCNT_W'(1);
          if (cnt_q == BCNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset cycle abandons the burst, including any beat presented alongside it.
    if (!reset_n) ram_we = 1'b0;
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rvld_q  <= (state_q == ST_RD);
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      wait_q  <= (state_d == ST_RD) || (state_d == ST_RD_DRAIN);
    end
  end

  dp_ram #(
    .DATA_WIDTH    (DATA_W),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .OP_REGISTERED ("UNREGISTERED"),
    .INIT_FILE     (INIT_FILE)
  ) u_ram (
    .clk       (clk),
    .wren_a    (ram_we),
    .address_a (ram_waddr),
    .data_a    (avs_writedata),
    .byteena_a ({(DATA_W/8){1'b1}}),
    .address_b (ptr_q),
    .q_b       (ram_rdata)
  );

  assign avs_waitrequest   = wait_q;
  assign avs_readdatavalid = rvld_q;
  assign avs_readdata      = rvld_q ? ram_rdata : '0;
  assign busy              = busy_q;
  assign burst_done        = done_q;

endmodule

// File: tb/tb_avm_burst_responder.sv
// Self-checking bench for avm_burst_responder: directed vector table, reset corner
// cases and randomized bursts checked against a word-array memory model.
module tb_avm_burst_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] avs_address;
  logic [11:0] avs_burstcount;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        busy;
  logic        burst_done;

  avm_burst_responder #(.ADDR_WIDTH(AW), .INIT_FILE("UNUSED")) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_burstcount    (avs_burstcount),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .busy              (busy),
    .burst_done        (burst_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed read beats and burst_done pulses, tagged with the cycle they appeared in.
  logic [31:0] beat_d[$];
  int          beat_c[$];
  int          done_c[$];
  int          rd_zero_viol = 0;

  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      beat_d.push_back(avs_readdata);
      beat_c.push_back(cyc);
    end else if (avs_readdata != 32'h0) begin
      rd_zero_viol++;
    end
    if (burst_done) done_c.push_back(cyc);
  end

  logic [31:0] mem_m [DEPTH];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_address    = 32'h0;
    avs_burstcount = 12'h0;
    avs_writedata  = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [11:0] bc, input int gap,
                          input logic [31:0] dbase, input bit rnd, input bit both,
                          output int nb);
    int n;
    int w;
    int b0;
    int d0;
    bit busy_ok;
    logic [31:0] d;
    n = (bc == 12'h0) ? 1 : int'(bc);
    w = int'(addr[AW+1:2]);
    b0 = beat_d.size();
    d0 = done_c.size();
    busy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          avs_write = 1'b0;
          avs_read  = 1'($urandom_range(0, 1));
          tick();
          if (!busy) busy_ok = 1'b0;
        end
      end
      d = rnd ? $urandom : dbase + 32'(i);
      avs_write      = 1'b1;
      avs_read       = (i == 0) ? both : 1'($urandom_range(0, 1));
      avs_address    = (i == 0) ? addr : $urandom;
      avs_burstcount = (i == 0) ? bc : 12'($urandom);
      avs_writedata  = d;
      mem_m[(w + i) % DEPTH] = d;
      tick();
      if (i < n - 1 && !busy) busy_ok = 1'b0;
    end
    idle_inputs();
    chk("wr_busy_in_burst", 32'(busy_ok), 32'd1);
    chk("wr_busy_after_last", 32'(busy), 32'd0);
    chk("wr_done_after_last", 32'(burst_done), 32'd1);
    tick();
    chk("wr_done_single_pulse", 32'(burst_done), 32'd0);
    chk("wr_done_count", 32'(done_c.size() - d0), 32'd1);
    nb = beat_d.size() - b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [11:0] bc, input bit noise,
                         input bit hold, output int nb, output logic [31:0] first,
                         output logic [31:0] last);
    int n;
    int w;
    int b0;
    int d0;
    int t;
    n = (bc == 12'h0) ? 1 : int'(bc);
    w = int'(addr[AW+1:2]);
    b0 = beat_d.size();
    d0 = done_c.size();
    t = cyc;
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    avs_address    = addr;
    avs_burstcount = bc;
    tick();
    chk("rd_wait_first", 32'(avs_waitrequest), 32'd1);
    chk("rd_busy_first", 32'(busy), 32'd1);
    for (int k = 0; k <= n; k++) begin
      if (k == n) begin
        chk("rd_drain_done", 32'(burst_done), 32'd1);
        chk("rd_drain_wait", 32'(avs_waitrequest), 32'd1);
      end
      avs_read       = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      avs_write      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      avs_writedata  = $urandom;
      avs_address    = $urandom;
      avs_burstcount = 12'($urandom);
      if (k < n) tick();
    end
    tick();
    idle_inputs();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_wait", 32'(avs_waitrequest), 32'd0);
    tick();
    tick();
    nb = beat_d.size() - b0;
    chk("rd_beat_count", 32'(nb), 32'(n));
    for (int k = 0; k < nb && k < n; k++) begin
      chk($sformatf("rd_beat%0d_cycle", k), 32'(beat_c[b0 + k]), 32'(t + 2 + k));
      chk($sformatf("rd_beat%0d_data", k), beat_d[b0 + k], mem_m[(w + k) % DEPTH]);
    end
    chk("rd_done_count", 32'(done_c.size() - d0), 32'd1);
    if (done_c.size() > d0) chk("rd_done_cycle", 32'(done_c[d0]), 32'(t + n + 1));
    first = (nb > 0) ? beat_d[b0] : 32'h0;
    last  = (nb > 0) ? beat_d[b0 + nb - 1] : 32'h0;
  endtask

  typedef struct {
    int          op;        // 0 write, 1 read, 2 read+write together, 3 read held high
    logic [31:0] addr;
    logic [11:0] bc;
    int          gap;
    logic [31:0] dbase;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int nb;
    int b0;
    int d0;
    logic [31:0] f;
    logic [31:0] l;

    vecs[0]  = '{0, 32'h100, 12'd4, 0, 32'hA0,       0, 32'h0,       32'h0};
    vecs[1]  = '{1, 32'h100, 12'd4, 0, 32'h0,        4, 32'hA0,      32'hA3};
    vecs[2]  = '{0, 32'h200, 12'd3, 2, 32'hB0,       0, 32'h0,       32'h0};
    vecs[3]  = '{1, 32'h200, 12'd3, 0, 32'h0,        3, 32'hB0,      32'hB2};
    vecs[4]  = '{0, 32'hFF8, 12'd4, 0, 32'hC0,       0, 32'h0,       32'h0};
    vecs[5]  = '{1, 32'hFF8, 12'd4, 0, 32'h0,        4, 32'hC0,      32'hC3};
    vecs[6]  = '{1, 32'h000, 12'd2, 0, 32'h0,        2, 32'hC2,      32'hC3};
    vecs[7]  = '{0, 32'h020, 12'd1, 0, 32'hD0,       0, 32'h0,       32'h0};
    vecs[8]  = '{3, 32'h020, 12'd0, 0, 32'h0,        1, 32'hD0,      32'hD0};
    vecs[9]  = '{2, 32'h040, 12'd1, 0, 32'h5A5A5A5A, 0, 32'h0,       32'h0};
    vecs[10] = '{1, 32'h040, 12'd1, 0, 32'h0,        1, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[11] = '{1, 32'h102, 12'd2, 0, 32'h0,        2, 32'hA0,      32'hA1};

    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    tick();
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Fill the whole memory so every later read has a known expected value.
    do_write(32'h0, 12'd1024, 0, 32'h0, 1'b1, 1'b0, nb);
    chk("fill_no_beats", 32'(nb), 32'd0);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].op == 0 || vecs[v].op == 2) begin
        do_write(vecs[v].addr, vecs[v].bc, vecs[v].gap, vecs[v].dbase, 1'b0,
                 vecs[v].op == 2, nb);
        chk($sformatf("vec%0d_beats", v), 32'(nb), 32'(vecs[v].exp_beats));
      end else begin
        do_read(vecs[v].addr, vecs[v].bc, 1'b0, vecs[v].op == 3, nb, f, l);
        chk($sformatf("vec%0d_beats", v), 32'(nb), 32'(vecs[v].exp_beats));
        chk($sformatf("vec%0d_first", v), f, vecs[v].exp_first);
        chk($sformatf("vec%0d_last", v), l, vecs[v].exp_last);
      end
    end

    // Reset two cycles into an 8-beat read.
    b0 = beat_d.size();
    d0 = done_c.size();
    avs_read       = 1'b1;
    avs_address    = 32'h100;
    avs_burstcount = 12'd8;
    tick();
    idle_inputs();
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrd_rst_valid", 32'(avs_readdatavalid), 32'd0);
    chk("midrd_rst_wait", 32'(avs_waitrequest), 32'd0);
    chk("midrd_rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("midrd_beats", 32'(beat_d.size() - b0), 32'd1);
    chk("midrd_no_done", 32'(done_c.size() - d0), 32'd0);
    do_read(32'h100, 12'd4, 1'b0, 1'b0, nb, f, l);
    chk("midrd_after_first", f, 32'hA0);

    // Reset after two beats of a 4-beat write: later beats must not land.
    avs_write      = 1'b1;
    avs_address    = 32'h300;
    avs_burstcount = 12'd4;
    avs_writedata  = 32'hE0;
    mem_m[32'h300 >> 2] = 32'hE0;
    tick();
    avs_writedata  = 32'hE1;
    mem_m[(32'h300 >> 2) + 1] = 32'hE1;
    tick();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    chk("midwr_rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    do_read(32'h300, 12'd4, 1'b0, 1'b0, nb, f, l);

    // Randomized bursts with stray commands while busy.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] a;
      logic [11:0] bc;
      a  = $urandom;
      bc = 12'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, bc, $urandom_range(0, 2), 32'h0, 1'b1, $urandom_range(0, 3) == 0, nb);
        chk("rnd_wr_no_beats", 32'(nb), 32'd0);
      end else begin
        do_read(a, bc, 1'b1, 1'b0, nb, f, l);
      end
    end

    chk("rdata_zero_when_invalid", 32'(rd_zero_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
